sseg_display_arbiter: RTL and testbench

Shares the 4-digit seven-segment display between two digit sources and drives the `d0`–`d3` inputs of the `Siete_Segmentos` driver.
- Source A is the always-present base view, such as time or counter value.
- Source B is a requester that shows a temporary message for a fixed number of time-base ticks, then must yield the display for a cooldown period.
- The block also blanks selected A digits on alternate ticks to produce blinking, for example to mark a field being edited.

---
 rtl/sseg_pkg.sv | 18 +
 rtl/sseg_display_arbiter_if.sv | 11 +
 rtl/sseg_tick_timer.sv | 30 +++
 rtl/sseg_display_arbiter.sv | 126 ++++++++++++
 tb/tb_sseg_display_arbiter.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment display arbiter slice:
// FSM state encoding, default blank digit code and packed-digit slicing.
package sseg_pkg;

    typedef enum logic [1:0] {
        SHOW_A   = 2'd0,
        SHOW_B   = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    localparam logic [3:0] BLANK_CODE_DEFAULT = 4'hF;

    // Extract digit idx (0 = least significant) from packed {d3,d2,d1,d0}.
    function automatic logic [3:0] digit_of(input logic [15:0] digits, input int unsigned idx);
        return digits[idx*4 +: 4];
    endfunction

endpackage

// File: rtl/sseg_display_arbiter_if.sv
// Source-B request/grant handshake toward the display arbiter.
interface sseg_display_arbiter_if;

    logic        b_req;
    logic [15:0] b_digits;
    logic        b_ack;

    modport master (output b_req, output b_digits, input  b_ack);
    modport slave  (input  b_req, input  b_digits, output b_ack);

endinterface

// File: rtl/sseg_tick_timer.sv
// Tick-driven counter with synchronous clear and terminal-count detect.
// done fires on the tick where the count equals term; the count then
// restarts from zero, so it never wraps.
module sseg_tick_timer #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             clr,
    input  logic [WIDTH-1:0] term,
    output logic             done
);

    logic [WIDTH-1:0] cnt;

    assign done = tick && !clr && (cnt == term);

    // Count ticks; clear on request or on reaching the terminal value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || done) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sseg_display_arbiter.sv
// Shares the 4-digit display between base view A (with optional blinking)
// and a temporary message source B that holds for HOLD_TICKS ticks and then
// yields for GAP_TICKS ticks before it may be granted again.
module sseg_display_arbiter
    import sseg_pkg::*;
#(
    parameter int unsigned HOLD_TICKS = 3,
    parameter int unsigned GAP_TICKS  = 2,
    parameter logic [3:0]  BLANK_CODE = BLANK_CODE_DEFAULT
) (
    input  logic                         clk_g,
    input  logic                         rst,
    input  logic                         tick,
    input  logic [15:0]                  a_digits,
    input  logic [3:0]                   blink_mask,
    sseg_display_arbiter_if.slave        bus,
    output logic                         sel_b,
    output logic                         cooldown,
    output logic [3:0]                   d0,
    output logic [3:0]                   d1,
    output logic [3:0]                   d2,
    output logic [3:0]                   d3
);

    localparam int unsigned MAX_TICKS = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
    localparam int unsigned CNT_W     = $clog2(MAX_TICKS + 1);
    localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    state_t           state;
    logic             phase;
    logic [15:0]      b_reg;
    logic [15:0]      d_reg;
    logic             b_ack_r;
    logic [15:0]      a_view;
    logic [CNT_W-1:0] term;
    logic             timer_clr;
    logic             timer_done;

    assign bus.b_ack = b_ack_r;
    assign d0 = digit_of(d_reg, 0);
    assign d1 = digit_of(d_reg, 1);
    assign d2 = digit_of(d_reg, 2);
    assign d3 = digit_of(d_reg, 3);

    // Timer is held clear in SHOW_A, so a tick coincident with acceptance
    // does not count toward HOLD.
    assign timer_clr = (state == SHOW_A);
    assign term      = (state == COOLDOWN) ? GAP_TERM : HOLD_TERM;

    sseg_tick_timer #(.WIDTH(CNT_W)) u_timer (
        .clk  (clk_g),
        .rst  (rst),
        .tick (tick),
        .clr  (timer_clr),
        .term (term),
        .done (timer_done)
    );

    // A view with blinked digits replaced by the blank code.
    always_comb begin
        a_view = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            a_view[i*4 +: 4] = (phase && blink_mask[i]) ? BLANK_CODE : digit_of(a_digits, i);
        end
    end

    // Arbitration FSM with registered grant, status and digit outputs.
    always_ff @(posedge clk_g) begin
        if (!rst) begin
            state    <= SHOW_A;
            phase    <= 1'b0;
            b_reg    <= '0;
            b_ack_r  <= 1'b0;
            sel_b    <= 1'b0;
            cooldown <= 1'b0;
            d_reg    <= {4{BLANK_CODE}};
        end else begin
            b_ack_r <= 1'b0;
            if (tick) begin
                phase <= ~phase;
            end
            case (state)
                SHOW_A: begin
                    if (bus.b_req) begin
                        state   <= SHOW_B;
                        b_reg   <= bus.b_digits;
                        b_ack_r <= 1'b1;
                        sel_b   <= 1'b1;
                        d_reg   <= bus.b_digits;
                    end else begin
                        d_reg <= a_view;
                    end
                end
                SHOW_B: begin
                    if (timer_done) begin
                        sel_b <= 1'b0;
                        d_reg <= a_view;
                        if (GAP_TICKS > 0) begin
                            state    <= COOLDOWN;
                            cooldown <= 1'b1;
                        end else begin
                            state <= SHOW_A;
                        end
                    end else begin
                        d_reg <= b_reg;
                    end
                end
                COOLDOWN: begin
                    d_reg <= a_view;
                    if (timer_done) begin
                        state    <= SHOW_A;
                        cooldown <= 1'b0;
                    end
                end
                default: begin
                    state    <= SHOW_A;
                    sel_b    <= 1'b0;
                    cooldown <= 1'b0;
                    d_reg    <= a_view;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sseg_display_arbiter.sv
// Directed self-checking bench for sseg_display_arbiter (HOLD=3, GAP=2).
module tb_sseg_display_arbiter;

    logic        clk_g = 1'b0;
    logic        rst;
    logic        tick;
    logic [15:0] a_digits;
    logic [3:0]  blink_mask;
    logic        sel_b;
    logic        cooldown;
    logic [3:0]  d0, d1, d2, d3;
    int unsigned errors = 0;
    int unsigned checks = 0;

    sseg_display_arbiter_if bus ();

    sseg_display_arbiter #(
        .HOLD_TICKS (3),
        .GAP_TICKS  (2),
        .BLANK_CODE (4'hF)
    ) dut (
        .clk_g      (clk_g),
        .rst        (rst),
        .tick       (tick),
        .a_digits   (a_digits),
        .blink_mask (blink_mask),
        .bus        (bus.slave),
        .sel_b      (sel_b),
        .cooldown   (cooldown),
        .d0         (d0),
        .d1         (d1),
        .d2         (d2),
        .d3         (d3)
    );

    always #5 clk_g = ~clk_g;

    // Inputs change and outputs are sampled just after the falling edge.
    task automatic cyc();
        @(negedge clk_g);
    endtask

    task automatic tick_cyc();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b0;
        tick         = 1'b0;
        a_digits     = 16'h1234;
        blink_mask   = 4'b0000;
        bus.b_req    = 1'b0;
        bus.b_digits = 16'h0000;

        // Reset
        cyc();
        chk("rst_digits", {d3, d2, d1, d0}, 16'hFFFF);
        chk("rst_ack", bus.b_ack, 1'b0);
        chk("rst_selb", sel_b, 1'b0);
        chk("rst_cool", cooldown, 1'b0);
        cyc();
        chk("rst_digits2", {d3, d2, d1, d0}, 16'hFFFF);
        rst = 1'b1;
        cyc();
        chk("post_rst_a", {d3, d2, d1, d0}, 16'h1234);
        chk("post_rst_selb", sel_b, 1'b0);

        // Grant and hold
        bus.b_req    = 1'b1;
        bus.b_digits = 16'hABCD;
        cyc();
        chk("grant_ack", bus.b_ack, 1'b1);
        chk("grant_selb", sel_b, 1'b1);
        chk("grant_digits", {d3, d2, d1, d0}, 16'hABCD);
        bus.b_req = 1'b0;
        cyc();
        chk("ack_one_cycle", bus.b_ack, 1'b0);
        chk("hold_digits0", {d3, d2, d1, d0}, 16'hABCD);
        tick_cyc();
        chk("hold_t1_selb", sel_b, 1'b1);
        tick_cyc();
        chk("hold_t2_selb", sel_b, 1'b1);
        chk("hold_t2_digits", {d3, d2, d1, d0}, 16'hABCD);
        cyc();
        chk("hold_idle_selb", sel_b, 1'b1);
        tick_cyc();
        chk("hold_end_selb", sel_b, 1'b0);
        chk("hold_end_cool", cooldown, 1'b1);
        chk("cool_a_digits", {d3, d2, d1, d0}, 16'h1234);

        // Pending request raised during cooldown
        bus.b_req    = 1'b1;
        bus.b_digits = 16'h9999;
        tick_cyc();
        chk("pend_cool1", cooldown, 1'b1);
        chk("pend_noack1", bus.b_ack, 1'b0);
        cyc();
        chk("pend_noack2", bus.b_ack, 1'b0);
        tick_cyc();
        chk("pend_cool_end", cooldown, 1'b0);
        chk("pend_noack3", bus.b_ack, 1'b0);
        chk("pend_showa", {d3, d2, d1, d0}, 16'h1234);
        cyc();
        chk("pend_ack", bus.b_ack, 1'b1);
        chk("pend_digits", {d3, d2, d1, d0}, 16'h9999);
        bus.b_req = 1'b0;
        cyc();
        chk("pend_ack_once", bus.b_ack, 1'b0);
        for (int i = 0; i < 5; i++) tick_cyc();
        chk("pend_back_selb", sel_b, 1'b0);
        chk("pend_back_cool", cooldown, 1'b0);

        // Blinking in SHOW_A (10 ticks so far, phase = 0)
        a_digits   = 16'h5678;
        blink_mask = 4'b0011;
        cyc();
        chk("blink_p0", {d3, d2, d1, d0}, 16'h5678);
        tick_cyc();
        cyc();
        chk("blink_p1", {d3, d2, d1, d0}, 16'h56FF);
        tick_cyc();
        cyc();
        chk("blink_p2", {d3, d2, d1, d0}, 16'h5678);
        tick_cyc();
        cyc();
        chk("blink_p3", {d3, d2, d1, d0}, 16'h56FF);
        tick_cyc();
        cyc();
        chk("blink_p4", {d3, d2, d1, d0}, 16'h5678);

        // Coincident tick and request (phase 0 before)
        tick         = 1'b1;
        bus.b_req    = 1'b1;
        bus.b_digits = 16'h1357;
        cyc();
        tick      = 1'b0;
        bus.b_req = 1'b0;
        chk("coin_ack", bus.b_ack, 1'b1);
        chk("coin_digits", {d3, d2, d1, d0}, 16'h1357);
        cyc();
        chk("coin_noblank", {d3, d2, d1, d0}, 16'h1357);
        tick_cyc();
        tick_cyc();
        chk("coin_still_b", sel_b, 1'b1);
        tick_cyc();
        chk("coin_exit_selb", sel_b, 1'b0);
        chk("coin_exit_cool", cooldown, 1'b1);
        chk("coin_phase", {d3, d2, d1, d0}, 16'h56FF);
        tick_cyc();
        chk("coin_cool_p0", {d3, d2, d1, d0}, 16'h5678);
        tick_cyc();
        chk("coin_cool_end", cooldown, 1'b0);

        // Reset in the middle of a message, request held throughout
        blink_mask   = 4'b0000;
        a_digits     = 16'h1234;
        bus.b_req    = 1'b1;
        bus.b_digits = 16'h2468;
        cyc();
        chk("mid_ack", bus.b_ack, 1'b1);
        tick_cyc();
        rst  = 1'b0;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk("mid_rst_selb", sel_b, 1'b0);
        chk("mid_rst_digits", {d3, d2, d1, d0}, 16'hFFFF);
        chk("mid_rst_ack", bus.b_ack, 1'b0);
        rst = 1'b1;
        cyc();
        chk("mid_reack", bus.b_ack, 1'b1);
        chk("mid_reack_digits", {d3, d2, d1, d0}, 16'h2468);
        bus.b_req = 1'b0;
        cyc();
        chk("mid_reack_once", bus.b_ack, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
